siso_frame_ctrl: RTL and testbench

//  Sequences a serial shift path. Accepts a parallel word through a valid/ready handshake,

---
 rtl/siso_frame_ctrl_pkg.sv | 14 +
 rtl/siso_frame_ctrl_if.sv | 23 ++
 rtl/siso_bit_counter.sv | 27 ++
 rtl/siso_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_siso_frame_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/siso_frame_ctrl_pkg.sv
// Shared definitions for the serial frame controller: FSM state codes and counter sizing.
package siso_frame_ctrl_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    // Bits needed to hold 0..n; never narrower than one bit so a zero-length gap still sizes.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/siso_frame_ctrl_if.sv
// Parallel-in handshake plus serial-out/status bundle of the frame controller.
interface siso_frame_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              serial_out;
    logic              serial_valid;
    logic              frame_start;
    logic              frame_done;
    logic              busy;

    modport master (
        output data_in, data_valid,
        input  data_ready, serial_out, serial_valid, frame_start, frame_done, busy
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, serial_out, serial_valid, frame_start, frame_done, busy
    );
endinterface

// File: rtl/siso_bit_counter.sv
// Loadable down-counter that saturates at zero; flags the last count via is_one.
module siso_bit_counter #(
    parameter int W = 4
) (
    input  logic         clock_in,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         is_one
);
    logic [W-1:0] count_reg;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign value  = count_reg;
    assign is_one = (count_reg == W'(1));
endmodule

// File: rtl/siso_frame_ctrl.sv
// Parallel-to-serial frame sequencer, MSB first, with start/done markers and an idle gap.
// Define SISO_FRAME_PARITY_EN to append an even-parity bit after the data bits.
module siso_frame_ctrl
    import siso_frame_ctrl_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clock_in,
    input  logic             reset,
    siso_frame_ctrl_if.slave bus
);
    localparam int BIT_W = cnt_w(DATA_W);
    localparam int GAP_W = cnt_w(GAP_CYCLES);

    logic [1:0]        state_reg, state_next;
    logic [DATA_W-1:0] sreg_reg;
    logic              done_reg, done_next;
    logic              accept, gap_load, gap_dec, bit_dec;
    logic              bit_is_one, gap_is_one;
    logic [BIT_W-1:0]  bit_value;
    logic [GAP_W-1:0]  gap_value;
`ifdef SISO_FRAME_PARITY_EN
    logic              parity_reg;
`endif

    assign accept  = (state_reg == S_IDLE) && bus.data_valid;
    assign bit_dec = (state_reg == S_SHIFT);
    assign gap_dec = (state_reg == S_GAP) && (|gap_value);

    siso_bit_counter #(.W(BIT_W)) u_bit_cnt (
        .clock_in   (clock_in),
        .reset      (reset),
        .load       (accept),
        .load_value (BIT_W'(DATA_W)),
        .dec        (bit_dec),
        .value      (bit_value),
        .is_one     (bit_is_one)
    );

    siso_bit_counter #(.W(GAP_W)) u_gap_cnt (
        .clock_in   (clock_in),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_W'(GAP_CYCLES)),
        .dec        (gap_dec),
        .value      (gap_value),
        .is_one     (gap_is_one)
    );

    // After the last frame bit: into the gap when one is configured, else straight to IDLE.
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        gap_load   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_is_one) begin
`ifdef SISO_FRAME_PARITY_EN
                    state_next = S_PARITY;
`else
                    done_next = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_next = S_GAP;
                        gap_load   = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
`endif
                end
            end
`ifdef SISO_FRAME_PARITY_EN
            S_PARITY: begin
                done_next = 1'b1;
                if (GAP_CYCLES > 0) begin
                    state_next = S_GAP;
                    gap_load   = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
`endif
            S_GAP: begin
                if (gap_is_one) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            sreg_reg   <= '0;
            done_reg   <= 1'b0;
`ifdef SISO_FRAME_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (accept) begin
                sreg_reg   <= bus.data_in;
`ifdef SISO_FRAME_PARITY_EN
                parity_reg <= ^bus.data_in;
`endif
            end else if (state_reg == S_SHIFT) begin
                sreg_reg <= {sreg_reg[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Ready is also masked by reset so nothing looks acceptable while reset is held.
    assign bus.data_ready  = (state_reg == S_IDLE) && !reset;
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.frame_start = (state_reg == S_SHIFT) && (bit_value == BIT_W'(DATA_W));
    assign bus.frame_done  = done_reg;
`ifdef SISO_FRAME_PARITY_EN
    assign bus.serial_valid = (state_reg == S_SHIFT) || (state_reg == S_PARITY);
    assign bus.serial_out   = (state_reg == S_SHIFT)  ? sreg_reg[DATA_W-1] :
                              (state_reg == S_PARITY) ? parity_reg : 1'b0;
`else
    assign bus.serial_valid = (state_reg == S_SHIFT);
    assign bus.serial_out   = (state_reg == S_SHIFT) ? sreg_reg[DATA_W-1] : 1'b0;
`endif
endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Bench: three controllers (gap 1, 0, 3) on shared stimulus, each checked per cycle against a frame-level model.
module tb_siso_frame_ctrl;
    localparam int DW = 8;
    localparam int NI = 3;
`ifdef SISO_FRAME_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    function automatic int gap_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    typedef struct packed {
        logic rdy;
        logic bsy;
        logic sv;
        logic so;
        logic fs;
        logic fd;
    } exp_t;

    localparam exp_t IDLE_EXP = '{rdy: 1'b1, bsy: 1'b0, sv: 1'b0, so: 1'b0, fs: 1'b0, fd: 1'b0};
    localparam exp_t RST_EXP  = '{rdy: 1'b0, bsy: 1'b0, sv: 1'b0, so: 1'b0, fs: 1'b0, fd: 1'b0};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic [5:0]    obs [NI];

    exp_t mq [NI][$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   reset_done = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        siso_frame_ctrl_if #(.DATA_W(DW)) bus ();
        assign bus.data_in    = data_in;
        assign bus.data_valid = data_valid;
        siso_frame_ctrl #(.DATA_W(DW), .GAP_CYCLES(gap_of(gi))) dut (
            .clock_in (clk),
            .reset    (reset),
            .bus      (bus.slave)
        );
        assign obs[gi] = {bus.data_ready, bus.busy, bus.serial_valid,
                          bus.serial_out, bus.frame_start, bus.frame_done};
    end

    task automatic chk(input string tag, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // Expected cycle-by-cycle view of one frame, built from the word alone.
    task automatic push_frame(input int i, input logic [DW-1:0] w);
        exp_t e;
        for (int b = 0; b < DW; b++) begin
            e = '{rdy: 1'b0, bsy: 1'b1, sv: 1'b1, so: w[DW-1-b], fs: (b == 0), fd: 1'b0};
            mq[i].push_back(e);
        end
        if (PAR == 1) begin
            e = '{rdy: 1'b0, bsy: 1'b1, sv: 1'b1, so: ^w, fs: 1'b0, fd: 1'b0};
            mq[i].push_back(e);
        end
        if (gap_of(i) > 0) begin
            for (int j = 0; j < gap_of(i); j++) begin
                e = '{rdy: 1'b0, bsy: 1'b1, sv: 1'b0, so: 1'b0, fs: 1'b0, fd: (j == 0)};
                mq[i].push_back(e);
            end
        end else begin
            e = '{rdy: 1'b1, bsy: 1'b0, sv: 1'b0, so: 1'b0, fs: 1'b0, fd: 1'b1};
            mq[i].push_back(e);
        end
    endtask

    task automatic compare(input int i, input exp_t e, input string when);
        exp_t o;
        o = exp_t'(obs[i]);
        chk($sformatf("u%0d.data_ready %s", i, when),   o.rdy, e.rdy);
        chk($sformatf("u%0d.busy %s", i, when),         o.bsy, e.bsy);
        chk($sformatf("u%0d.serial_valid %s", i, when), o.sv,  e.sv);
        if (e.sv || e.bsy)
            chk($sformatf("u%0d.serial_out %s", i, when), o.so, e.so);
        chk($sformatf("u%0d.frame_start %s", i, when),  o.fs,  e.fs);
        chk($sformatf("u%0d.frame_done %s", i, when),   o.fd,  e.fd);
    endtask

    initial begin
        exp_t e;
        exp_t e0;
        #12;
        for (int i = 0; i < NI; i++) compare(i, RST_EXP, "in_reset");
        @(posedge clk);
        #1 reset = 1'b0;

        for (cyc = 0; cyc < 400; cyc++) begin
            if (cyc < 20) begin
                data_valid = 1'b1; data_in = 8'hA5;
            end else if (cyc < 40) begin
                data_valid = 1'b1; data_in = (cyc < 30) ? 8'hFF : 8'h00;
            end else if (cyc < 80) begin
                data_valid = 1'b1; data_in = 8'h3C;
            end else if (cyc < 120) begin
                data_valid = 1'b1; data_in = (cyc < 100) ? 8'h07 : 8'h03;
            end else begin
                data_valid = ($urandom_range(0, 3) != 0);
                data_in    = DW'($urandom);
            end

            @(negedge clk);
            e0 = IDLE_EXP;
            for (int i = 0; i < NI; i++) begin
                e = (mq[i].size() == 0) ? IDLE_EXP : mq[i].pop_front();
                if (i == 0) e0 = e;
                compare(i, e, $sformatf("c%0d", cyc));
                if (e.rdy && data_valid) begin
                    $display("u%0d accepted 0x%h at cycle %0d", i, data_in, cyc);
                    push_frame(i, data_in);
                end
            end

            // Abort one frame mid-shift: outputs must drop at once and no done may follow.
            if (!reset_done && cyc >= 150 && e0.sv && mq[0].size() > 0 && mq[0][0].sv) begin
                #2 reset = 1'b1;
                #1;
                for (int i = 0; i < NI; i++) begin
                    compare(i, RST_EXP, $sformatf("mid_reset c%0d", cyc));
                    mq[i].delete();
                end
                reset_done = 1'b1;
                $display("reset asserted mid-frame at cycle %0d", cyc);
            end

            @(posedge clk);
            #1 reset = 1'b0;
        end

        chk("mid_reset_applied", reset_done, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
